// File: rtl/serial_adder_n_pkg.sv
// rtl/serial_adder_n_pkg.sv - shared FSM state encoding for the bit-serial adder
// Purpose: holds the 2-bit IDLE/RUN/DONE state encoding used by serial_adder_n.
// Ports: none (package).
package serial_adder_n_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_n_if.sv
// rtl/serial_adder_n_if.sv - request/result bundle of the bit-serial adder
// Purpose: groups the start handshake, operands and registered results.
// Ports (master = requester, slave = adder):
//   start, sub, a, b, cin : master -> slave
//   busy, done, sum, cout, ovf : slave -> master
interface serial_adder_n_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/serial_adder_n_full_adder_cell.sv
// rtl/serial_adder_n_full_adder_cell.sv - single-bit combinational full adder
// Purpose: the one adder cell the serial adder iterates over every bit.
// Ports:
//   a_i, b_i, cin_i : operand bits and carry in
//   s_o             : sum bit
//   co_o            : carry out (majority of the three inputs)
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ cin_i;
  assign co_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_adder_n.sv
// rtl/serial_adder_n.sv - bit-serial adder/subtractor, LSB first, one bit per clock
// Purpose: adds or subtracts two WIDTH-bit operands with a single full-adder
//   cell, WIDTH clocks per operation, with start/busy/done handshake, carry
//   out and signed overflow.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active-low
//   bus   : slave side of serial_adder_n_if (start/sub/a/b/cin in,
//           busy/done/sum/cout/ovf out)
module serial_adder_n
  import serial_adder_n_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_adder_n_if.slave   bus
);

  localparam int                CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               fa_s, fa_co;

  full_adder_cell u_fa (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cin_i (carry_q),
    .s_o   (fa_s),
    .co_o  (fa_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          // Subtract is a + ~b + 1: invert B once at load and seed carry with 1.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        carry_d          = fa_co;
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = fa_s;
        cnt_d            = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // On the MSB step carry_q is the carry into the MSB, so ovf needs
          // no extra storage.
          sum_d   = res_d;
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// tb/tb_serial_adder_n.sv - self-checking bench for serial_adder_n (WIDTH=8 and WIDTH=1)
module tb_serial_adder_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  serial_adder_n_if #(.WIDTH(8)) bus8 ();
  serial_adder_n_if #(.WIDTH(1)) bus1 ();

  serial_adder_n #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder_n #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: arithmetic on plain integers, unsigned for sum/cout, signed for ovf.
  task automatic model(input int w, input int a, input int b, input int cin,
                       input int sub, output int s, output int co, output int ov);
    int m, sa, sb, u, r;
    m  = 1 << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (sub != 0) begin
      u  = a - b;
      r  = sa - sb;
      co = (a >= b) ? 1 : 0;
    end else begin
      u  = a + b + cin;
      r  = sa + sb + cin;
      co = (u >= m) ? 1 : 0;
    end
    s  = ((u % m) + m) % m;
    ov = (r < -(m / 2) || r > m / 2 - 1) ? 1 : 0;
  endtask

  task automatic op8(input int a, input int b, input int cin, input int sub, input string tag);
    int s, co, ov, e;
    model(8, a, b, cin, sub, s, co, ov);
    @(negedge clk);
    bus8.a = 8'(a); bus8.b = 8'(b); bus8.cin = 1'(cin); bus8.sub = 1'(sub);
    bus8.start = 1'b1;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    chk({tag, ".busy"}, int'(bus8.busy), 1);
    e = 0;
    while (!bus8.done && e < 20) begin
      @(posedge clk); #1 e++;
    end
    chk({tag, ".latency"}, e, 8);
    chk({tag, ".sum"}, int'(bus8.sum), s);
    chk({tag, ".cout"}, int'(bus8.cout), co);
    chk({tag, ".ovf"}, int'(bus8.ovf), ov);
    chk({tag, ".busy_in_done"}, int'(bus8.busy), 0);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, int'(bus8.done), 0);
  endtask

  initial begin
    int s, co, ov, e, n;
    int ra, rb, rc, rs;
    bus8.start = 0; bus8.a = 0; bus8.b = 0; bus8.cin = 0; bus8.sub = 0;
    bus1.start = 0; bus1.a = 0; bus1.b = 0; bus1.cin = 0; bus1.sub = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", int'(bus8.busy), 0);
    chk("rst.done", int'(bus8.done), 0);
    chk("rst.sum",  int'(bus8.sum), 0);
    chk("rst.cout", int'(bus8.cout), 0);
    chk("rst.ovf",  int'(bus8.ovf), 0);
    chk("rst1.done", int'(bus1.done), 0);
    rst_n = 1'b1;

    // Directed vectors
    op8(8'h5A, 8'h33, 0, 0, "add5A33");
    op8(8'hFF, 8'h01, 0, 0, "addFF01");
    op8(8'h7F, 8'h00, 1, 0, "add7F00c");
    op8(8'h10, 8'h20, 0, 1, "sub1020");
    op8(8'h80, 8'h01, 0, 1, "sub8001");
    op8(8'h80, 8'h00, 1, 1, "sub8000");

    // Random vectors
    for (int i = 0; i < 40; i++) begin
      op8(int'($urandom_range(255)), int'($urandom_range(255)),
          int'($urandom_range(1)), int'($urandom_range(1)), $sformatf("rnd%0d", i));
    end

    // start during RUN is ignored
    ra = 8'h3C; rb = 8'h4B; rc = 1;
    model(8, ra, rb, rc, 0, s, co, ov);
    @(negedge clk);
    bus8.a = 8'(ra); bus8.b = 8'(rb); bus8.cin = 1'(rc); bus8.sub = 0; bus8.start = 1;
    @(posedge clk); #1 bus8.start = 0;
    repeat (3) @(posedge clk);
    #1 bus8.a = 8'hE1; bus8.b = 8'h99; bus8.sub = 1; bus8.start = 1;
    @(posedge clk); #1 bus8.start = 0;
    e = 4; n = 0;
    while (!bus8.done && e < 20) begin
      @(posedge clk); #1 e++;
    end
    chk("ign.latency", e, 8);
    chk("ign.sum", int'(bus8.sum), s);
    chk("ign.cout", int'(bus8.cout), co);
    chk("ign.ovf", int'(bus8.ovf), ov);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1 if (bus8.done) n++;
    end
    chk("ign.extra_done", n, 0);

    // Reset mid-RUN aborts the operation (previous sum is nonzero)
    @(negedge clk);
    bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 0; bus8.sub = 0; bus8.start = 1;
    @(posedge clk); #1 bus8.start = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    chk("abort.busy", int'(bus8.busy), 0);
    chk("abort.sum", int'(bus8.sum), 0);
    chk("abort.cout", int'(bus8.cout), 0);
    chk("abort.ovf", int'(bus8.ovf), 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1 if (bus8.done) n++;
    end
    chk("abort.no_done", n, 0);
    op8(8'hC3, 8'h5D, 1, 0, "after_abort");

    // WIDTH=1 truth table, start held high for back-to-back operations
    @(negedge clk);
    bus1.a = 0; bus1.b = 0; bus1.cin = 0; bus1.sub = 0; bus1.start = 1;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      ra = (i >> 2) & 1; rb = (i >> 1) & 1; rc = i & 1;
      #1;
      chk($sformatf("w1.%0d.busy", i), int'(bus1.busy), 1);
      chk($sformatf("w1.%0d.done_run", i), int'(bus1.done), 0);
      if (i < 7) begin
        bus1.a = 1'(((i + 1) >> 2) & 1);
        bus1.b = 1'(((i + 1) >> 1) & 1);
        bus1.cin = 1'((i + 1) & 1);
      end else begin
        bus1.start = 0;
      end
      @(posedge clk); #1;
      rs = ra + rb + rc;
      model(1, ra, rb, rc, 0, s, co, ov);
      chk($sformatf("w1.%0d.done", i), int'(bus1.done), 1);
      chk($sformatf("w1.%0d.cout_sum", i), int'({bus1.cout, bus1.sum}), rs);
      chk($sformatf("w1.%0d.ovf", i), int'(bus1.ovf), ov);
      @(posedge clk);
    end
    #1;
    chk("w1.idle", int'(bus1.done) + int'(bus1.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
